// File: rtl/uart_mem_bridge.sv
// UART command-packet bridge: parses W/R packets from the RX byte stream,
// performs one byte-wide memory access and returns a single response byte.
module uart_mem_bridge #(
  parameter int D_ADDR_W       = 12,
  parameter int READ_LATENCY   = 1,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [7:0]          rx_data,
  input  logic                rx_valid,
  output logic                rx_ready,
  output logic [7:0]          tx_data,
  output logic                tx_valid,
  input  logic                tx_ready,
  output logic [D_ADDR_W-1:0] mem_addr,
  output logic                mem_write_enable,
  output logic [7:0]          mem_write_data,
  input  logic [7:0]          mem_read_data,
  output logic                busy,
  output logic                cmd_error
);

  localparam int TW =
    (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TW-1:0] TMO_LAST =
    (TIMEOUT_CYCLES > 0) ? TW'(TIMEOUT_CYCLES - 1) : '0;
  localparam logic [2:0] RD_LAST = 3'(READ_LATENCY);

  localparam logic [7:0] CMD_W   = 8'h57;
  localparam logic [7:0] CMD_R   = 8'h52;
  localparam logic [7:0] RSP_OK  = 8'h4B;
  localparam logic [7:0] RSP_BAD = 8'h3F;

  typedef enum logic [2:0] {
    IDLE,
    ADDR_HI,
    ADDR_LO,
    DATA,
    MEM_WR,
    MEM_RD,
    RESP
  } state_t;

  state_t          state;
  state_t          state_nx;
  logic            is_wr;
  logic            is_wr_nx;
  logic [7:0]      addr_hi;
  logic [2:0]      rd_cnt;
  logic [TW-1:0]   tmo_cnt;
  logic [7:0]      tx_nx;
  logic            err_nx;
  logic            ld_hi;
  logic            ld_lo;
  logic            ld_wd;
  logic            rx_fire;
  logic            counting;
  logic            tmo_hit;

  assign rx_fire  = rx_valid && rx_ready;
  assign counting = (TIMEOUT_CYCLES != 0) &&
                    (state inside {ADDR_HI, ADDR_LO, DATA});

  always_comb begin
    state_nx = state;
    is_wr_nx = is_wr;
    tx_nx    = tx_data;
    err_nx   = 1'b0;
    ld_hi    = 1'b0;
    ld_lo    = 1'b0;
    ld_wd    = 1'b0;
    // an accepted byte in the expiry cycle keeps the packet alive
    tmo_hit  = counting && !rx_fire && (tmo_cnt == TMO_LAST);
    unique case (state)
      IDLE: begin
        if (rx_fire) begin
          if (rx_data == CMD_W || rx_data == CMD_R) begin
            state_nx = ADDR_HI;
            is_wr_nx = (rx_data == CMD_W);
          end else begin
            state_nx = RESP;
            tx_nx    = RSP_BAD;
            err_nx   = 1'b1;
          end
        end
      end
      ADDR_HI: begin
        if (rx_fire) begin
          state_nx = ADDR_LO;
          ld_hi    = 1'b1;
        end
      end
      ADDR_LO: begin
        if (rx_fire) begin
          state_nx = is_wr ? DATA : MEM_RD;
          ld_lo    = 1'b1;
        end
      end
      DATA: begin
        if (rx_fire) begin
          state_nx = MEM_WR;
          ld_wd    = 1'b1;
        end
      end
      MEM_WR: begin
        state_nx = RESP;
        tx_nx    = RSP_OK;
      end
      MEM_RD: begin
        if (rd_cnt == RD_LAST) begin
          state_nx = RESP;
          tx_nx    = mem_read_data;
        end
      end
      RESP: begin
        if (tx_valid && tx_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    if (tmo_hit) begin
      state_nx = IDLE;
      err_nx   = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= IDLE;
      is_wr            <= 1'b0;
      addr_hi          <= '0;
      rd_cnt           <= '0;
      tmo_cnt          <= '0;
      rx_ready         <= 1'b0;
      tx_data          <= '0;
      tx_valid         <= 1'b0;
      mem_addr         <= '0;
      mem_write_enable <= 1'b0;
      mem_write_data   <= '0;
      busy             <= 1'b0;
      cmd_error        <= 1'b0;
    end else begin
      state            <= state_nx;
      is_wr            <= is_wr_nx;
      tx_data          <= tx_nx;
      cmd_error        <= err_nx;
      rx_ready         <= state_nx inside {IDLE, ADDR_HI, ADDR_LO, DATA};
      tx_valid         <= (state_nx == RESP);
      mem_write_enable <= (state_nx == MEM_WR);
      busy             <= (state_nx != IDLE);
      if (ld_hi) addr_hi <= rx_data;
      if (ld_lo) mem_addr <= D_ADDR_W'({addr_hi, rx_data});
      if (ld_wd) mem_write_data <= rx_data;
      rd_cnt  <= (state == MEM_RD && state_nx == MEM_RD) ?
                 rd_cnt + 3'd1 : 3'd0;
      tmo_cnt <= (counting && !rx_fire && !tmo_hit) ?
                 tmo_cnt + TW'(1) : '0;
    end
  end

endmodule
